// File: rtl/proc_pkg.sv
// Shared definitions for the parametrised bus processor: opcodes, step codes,
// ALU operation select and a constant-evaluable clog2.
package proc_pkg;

   localparam logic [3:0] OP_MV   = 4'd0;
   localparam logic [3:0] OP_MVI  = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_OR   = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_MVNZ = 4'd10;
   localparam logic [3:0] OP_MVC  = 4'd11;

   typedef logic [1:0] step_t;
   localparam step_t T0 = 2'd0;
   localparam step_t T1 = 2'd1;
   localparam step_t T2 = 2'd2;
   localparam step_t T3 = 2'd3;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL
   } alu_op_t;

   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      while ((1 << bits) < value) bits++;
      return bits;
   endfunction

   function automatic logic is_alu_op(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_SRL);
   endfunction

   function automatic alu_op_t alu_sel(input logic [3:0] op);
      alu_op_t sel;
      case (op)
         OP_SUB:  sel = ALU_SUB;
         OP_AND:  sel = ALU_AND;
         OP_OR:   sel = ALU_OR;
         OP_XOR:  sel = ALU_XOR;
         OP_SLT:  sel = ALU_SLT;
         OP_SLL:  sel = ALU_SLL;
         OP_SRL:  sel = ALU_SRL;
         default: sel = ALU_ADD;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU for proc_param. With PROC_FLAGS_EN defined it also
// reports carry/borrow and signed overflow for add and sub.
module proc_alu
   import proc_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  alu_op_t          op,
   output logic [WIDTH-1:0] result,
   output logic             zero
`ifdef PROC_FLAGS_EN
   ,
   output logic             carry,
   output logic             overflow
`endif
);

   localparam int SHW = clog2(WIDTH);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SHW-1:0]   shamt;

   assign shamt = b[SHW-1:0];

`ifdef PROC_FLAGS_EN
   logic sum_carry;
   logic diff_borrow;

   assign {sum_carry, sum}    = {1'b0, a} + {1'b0, b};
   assign {diff_borrow, diff} = {1'b0, a} - {1'b0, b};

   // Sub reports borrow rather than carry, so 0 - 1 sets the flag.
   always_comb begin
      carry    = 1'b0;
      overflow = 1'b0;
      case (op)
         ALU_ADD: begin
            carry    = sum_carry;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            carry    = diff_borrow;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         default: ;
      endcase
   end
`else
   assign sum  = a + b;
   assign diff = a - b;
`endif

   always_comb begin
      result = '0;
      case (op)
         ALU_ADD: result = sum;
         ALU_SUB: result = diff;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLL: result = a << shamt;
         ALU_SRL: result = a >> shamt;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/proc_param.sv
// Parametrised multi-cycle bus processor with Run/Done handshake.
// Optional PROC_FLAGS_EN adds the Flags port {N,Z,C,V} and the mvc opcode.
module proc_param
   import proc_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int NREGS = 8
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Run,
   input  logic [WIDTH-1:0] DIN,
   output logic             Done,
`ifdef PROC_FLAGS_EN
   output logic [3:0]       Flags,
`endif
   output logic [WIDTH-1:0] BusWires
);

   localparam int RB = clog2(NREGS);

   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] g_reg;
   logic [3:0]       ir_op;
   logic [RB-1:0]    ir_rx;
   logic [RB-1:0]    ir_ry;
   step_t            step;
   logic             z_flag;
   logic             rx_we;
   alu_op_t          alu_op;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

`ifdef PROC_FLAGS_EN
   logic n_flag;
   logic c_flag;
   logic v_flag;
   logic alu_carry;
   logic alu_overflow;
`endif

   assign alu_op = alu_sel(ir_op);

   proc_alu #(.WIDTH(WIDTH)) u_alu (
      .a        (a_reg),
      .b        (BusWires),
      .op       (alu_op),
      .result   (alu_result),
`ifdef PROC_FLAGS_EN
      .carry    (alu_carry),
      .overflow (alu_overflow),
`endif
      .zero     (alu_zero)
   );

   // One bus source per step; every register write takes its data from the bus.
   always_comb begin
      BusWires = '0;
      Done     = 1'b0;
      rx_we    = 1'b0;
      case (step)
         T1: begin
            Done = !is_alu_op(ir_op);
            if (ir_op == OP_MV) begin
               BusWires = regs[ir_ry];
               rx_we    = 1'b1;
            end else if (ir_op == OP_MVI) begin
               BusWires = DIN;
               rx_we    = 1'b1;
            end else if (ir_op == OP_MVNZ) begin
               BusWires = regs[ir_ry];
               rx_we    = !z_flag;
`ifdef PROC_FLAGS_EN
            end else if (ir_op == OP_MVC) begin
               BusWires = regs[ir_ry];
               rx_we    = c_flag;
`endif
            end else if (is_alu_op(ir_op)) begin
               BusWires = regs[ir_rx];
            end
         end
         T2: BusWires = regs[ir_ry];
         T3: begin
            BusWires = g_reg;
            Done     = 1'b1;
            rx_we    = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         step   <= T0;
         ir_op  <= '0;
         ir_rx  <= '0;
         ir_ry  <= '0;
         a_reg  <= '0;
         g_reg  <= '0;
         z_flag <= 1'b1;
      end else begin
         case (step)
            T0: begin
               if (Run) begin
                  ir_op <= DIN[WIDTH-1 -: 4];
                  ir_rx <= DIN[WIDTH-5 -: RB];
                  ir_ry <= DIN[WIDTH-5-RB -: RB];
                  step  <= T1;
               end
            end
            T1: begin
               if (is_alu_op(ir_op)) begin
                  a_reg <= BusWires;
                  step  <= T2;
               end else begin
                  step <= T0;
               end
            end
            T2: begin
               g_reg  <= alu_result;
               z_flag <= alu_zero;
               step   <= T3;
            end
            default: step <= T0;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (rx_we) begin
         regs[ir_rx] <= BusWires;
      end
   end

`ifdef PROC_FLAGS_EN
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         n_flag <= 1'b0;
         c_flag <= 1'b0;
         v_flag <= 1'b0;
      end else if (step == T2) begin
         n_flag <= alu_result[WIDTH-1];
         c_flag <= alu_carry;
         v_flag <= alu_overflow;
      end
   end

   assign Flags = {n_flag, z_flag, c_flag, v_flag};
`endif

endmodule

// File: tb/tb_proc_param.sv
// Bench for proc_param at WIDTH=16, NREGS=8: directed steps and randomized
// instructions checked against an instruction-level model of the processor.
module tb_proc_param;

   logic        Clock  = 1'b0;
   logic        Resetn = 1'b0;
   logic        Run    = 1'b0;
   logic [15:0] DIN    = '0;
   logic        Done;
   logic [15:0] BusWires;
`ifdef PROC_FLAGS_EN
   logic [3:0]  Flags;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] m_regs [8];
   logic        m_z, m_n, m_c, m_v;
   logic [3:0]  flags_at_done;

   proc_param #(.WIDTH(16), .NREGS(8)) dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .Run      (Run),
      .DIN      (DIN),
      .Done     (Done),
`ifdef PROC_FLAGS_EN
      .Flags    (Flags),
`endif
      .BusWires (BusWires)
   );

   always #5 Clock = ~Clock;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_z = 1'b1;
      m_n = 1'b0;
      m_c = 1'b0;
      m_v = 1'b0;
   endtask

   // Instruction-level arithmetic on plain integers.
   task automatic aluModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] r);
      int ua, ub, sa, sb, wide, swide;
      ua = int'(a);
      ub = int'(b);
      sa = int'($signed(a));
      sb = int'($signed(b));
      m_c = 1'b0;
      m_v = 1'b0;
      case (op)
         4'd2: begin
            wide  = ua + ub;
            swide = sa + sb;
            r     = 16'(wide);
            m_c   = (wide > 65535);
            m_v   = (swide > 32767) || (swide < -32768);
         end
         4'd3: begin
            wide  = ua - ub;
            swide = sa - sb;
            r     = 16'(wide);
            m_c   = (ua < ub);
            m_v   = (swide > 32767) || (swide < -32768);
         end
         4'd4: r = a & b;
         4'd5: r = a | b;
         4'd6: r = a ^ b;
         4'd7: r = (sa < sb) ? 16'd1 : 16'd0;
         4'd8: r = a << (ub % 16);
         4'd9: r = a >> (ub % 16);
         default: r = '0;
      endcase
      m_z = (r == 16'd0);
      m_n = r[15];
   endtask

   // Runs one instruction, updates the model and checks Done timing and the bus.
   task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry,
                                input logic [15:0] imm);
      logic [15:0] a, b, r, exp_bus, bus_at_done;
      int          exp_cyc, cyc, done_cyc;
      bit          check_bus, is_alu;
      a         = m_regs[rx];
      b         = m_regs[ry];
      exp_cyc   = 1;
      exp_bus   = '0;
      check_bus = 1'b1;
      is_alu    = (op >= 4'd2) && (op <= 4'd9);
      if (op == 4'd0) begin
         exp_bus    = b;
         m_regs[rx] = b;
      end else if (op == 4'd1) begin
         exp_bus    = imm;
         m_regs[rx] = imm;
      end else if (op == 4'd10) begin
         check_bus = 1'b0;
         if (!m_z) m_regs[rx] = b;
`ifdef PROC_FLAGS_EN
      end else if (op == 4'd11) begin
         check_bus = 1'b0;
         if (m_c) m_regs[rx] = b;
`endif
      end else if (is_alu) begin
         aluModel(op, a, b, r);
         exp_cyc    = 3;
         exp_bus    = r;
         m_regs[rx] = r;
      end

      @(negedge Clock);
      DIN = {op, rx, ry, 6'($urandom)};
      Run = 1'b1;
      @(posedge Clock);
      #1;
      Run = 1'($urandom);
      DIN = (op == 4'd1) ? imm : 16'($urandom);
      cyc         = 0;
      done_cyc    = 0;
      bus_at_done = '0;
      while (done_cyc == 0 && cyc < 6) begin
         @(negedge Clock);
         cyc++;
         if (Done === 1'b1) begin
            done_cyc    = cyc;
            bus_at_done = BusWires;
`ifdef PROC_FLAGS_EN
            flags_at_done = Flags;
`endif
         end
         @(posedge Clock);
         #1;
         Run = 1'($urandom);
         DIN = 16'($urandom);
      end
      Run = 1'b0;

      checkOutput($sformatf("op%0d_done_cycle", op), 16'(done_cyc), 16'(exp_cyc));
      if (check_bus) checkOutput($sformatf("op%0d_r%0d_bus", op, rx), bus_at_done, exp_bus);
`ifdef PROC_FLAGS_EN
      if (is_alu) checkOutput($sformatf("op%0d_flags", op), 16'(flags_at_done), 16'({m_n, m_z, m_c, m_v}));
`endif
   endtask

   task automatic readReg(input logic [2:0] k);
      applyStimulus(4'd0, k, k, 16'd0);
   endtask

   task automatic readAll();
      for (int k = 0; k < 8; k++) readReg(3'(k));
   endtask

   initial begin
      logic [3:0] rop;
      $display("[TB] start");
      modelReset();
      flags_at_done = '0;

      // Reset state.
      Resetn = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      checkOutput("reset_done", 16'(Done), 16'd0);
      checkOutput("reset_bus", BusWires, 16'd0);
`ifdef PROC_FLAGS_EN
      checkOutput("reset_flags", 16'(Flags), 16'h0004);
`endif
      @(negedge Clock);
      Resetn = 1'b1;
      readAll();

      // Immediate load.
      applyStimulus(4'd1, 3'd0, 3'd0, 16'h1234);
      readReg(3'd0);

      // Add wrapping to zero, then mvnz must not move.
      applyStimulus(4'd1, 3'd1, 3'd0, 16'h0001);
      applyStimulus(4'd1, 3'd0, 3'd0, 16'hFFFF);
      applyStimulus(4'd1, 3'd2, 3'd0, 16'h5555);
      applyStimulus(4'd2, 3'd1, 3'd0, 16'h0000);
      applyStimulus(4'd10, 3'd2, 3'd0, 16'h0000);
      readReg(3'd1);
      readReg(3'd2);

      // Signed compare and shift.
      applyStimulus(4'd1, 3'd3, 3'd0, 16'h8000);
      applyStimulus(4'd1, 3'd4, 3'd0, 16'h0001);
      applyStimulus(4'd7, 3'd3, 3'd4, 16'h0000);
      applyStimulus(4'd1, 3'd5, 3'd0, 16'h0003);
      applyStimulus(4'd1, 3'd6, 3'd0, 16'h0014);
      applyStimulus(4'd8, 3'd5, 3'd6, 16'h0000);
      readReg(3'd3);
      readReg(3'd5);

      // Same register on both sides doubles it.
      applyStimulus(4'd2, 3'd6, 3'd6, 16'h0000);
      readReg(3'd6);

      // Idle with Run low.
      for (int i = 0; i < 5; i++) begin
         @(negedge Clock);
         DIN = 16'($urandom);
         checkOutput("idle_done", 16'(Done), 16'd0);
         checkOutput("idle_bus", BusWires, 16'd0);
      end
      readAll();

      // Illegal opcode leaves everything alone, including Z (cleared by sll).
      applyStimulus(4'd13, 3'd7, 3'd5, 16'h0000);
      readAll();
      applyStimulus(4'd10, 3'd7, 3'd5, 16'h0000);
      readReg(3'd7);

`ifdef PROC_FLAGS_EN
      applyStimulus(4'd1, 3'd1, 3'd0, 16'h7FFF);
      applyStimulus(4'd1, 3'd2, 3'd0, 16'h0001);
      applyStimulus(4'd2, 3'd1, 3'd2, 16'h0000);
      checkOutput("flags_add_ovf", 16'(flags_at_done), 16'h0009);
      applyStimulus(4'd1, 3'd3, 3'd0, 16'h0000);
      applyStimulus(4'd1, 3'd4, 3'd0, 16'h0001);
      applyStimulus(4'd3, 3'd3, 3'd4, 16'h0000);
      checkOutput("flags_sub_borrow", 16'(flags_at_done), 16'h000A);
      applyStimulus(4'd11, 3'd5, 3'd4, 16'h0000);
      readReg(3'd5);
`endif

      // Randomized instruction stream.
      for (int i = 0; i < 200; i++) begin
         rop = 4'($urandom_range(0, 15));
         applyStimulus(rop, 3'($urandom), 3'($urandom), 16'($urandom));
         if ((i % 10) == 9) readReg(3'($urandom));
      end
      readAll();

      // Reset during T2 of sub.
      applyStimulus(4'd1, 3'd1, 3'd0, 16'h1111);
      applyStimulus(4'd1, 3'd2, 3'd0, 16'hA5A5);
      @(negedge Clock);
      DIN = {4'd3, 3'd1, 3'd2, 6'd0};
      Run = 1'b1;
      @(posedge Clock);
      #1;
      Run = 1'b0;
      @(posedge Clock);
      #2;
      checkOutput("t2_bus_before_reset", BusWires, m_regs[2]);
      Resetn = 1'b0;
      #1;
      checkOutput("midreset_done", 16'(Done), 16'd0);
      checkOutput("midreset_bus", BusWires, 16'd0);
      modelReset();
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Resetn = 1'b1;
      readAll();

      // Z is set again after reset, so mvnz must not move.
      applyStimulus(4'd1, 3'd4, 3'd0, 16'h0F0F);
      applyStimulus(4'd10, 3'd3, 3'd4, 16'h0000);
      readReg(3'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/proc_param.md
Name: proc_param

Overview:
- Parametrised successor of the team's 16-bit multi-cycle bus processor.
- Generalised in data width and register-file depth, with a wider opcode field, more ALU operations, a registered zero flag and defined handling of illegal opcodes.
- Sits between the instruction/data source that drives DIN and any bus observer; single shared bus, Run/Done handshake per instruction.

Parameters:
- WIDTH, 16, data/bus width in bits; must satisfy WIDTH >= 4 + 2*RB.
- NREGS, 8, number of general registers; power of two, 2..16; RB = clog2(NREGS).

Ports:
- Clock  in  1  single clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request, sampled in step T0.
- DIN  in  WIDTH  instruction word in T0; immediate data in T1 for mvi.
- Done  out  1  high for exactly the final cycle of each instruction.
- BusWires  out  WIDTH  current value of the shared bus.

Behaviour:
- Instruction fields, taken from DIN in T0:
  - op = DIN[WIDTH-1 -: 4]
  - rx = next RB bits
  - ry = next RB bits
  - remaining bits ignored.
- Step counter states: T0, T1, T2, T3.
  - T0 with Run=0: stay in T0, nothing written.
  - T0 with Run=1: IR <= fields; go to T1.
- Opcodes:
  - 0 mv: T1 bus=Ry, Rx<=bus, Done.
  - 1 mvi: T1 bus=DIN, Rx<=bus, Done.
  - 10 mvnz: T1 Rx<=Ry only if Z=0, Done either way.
  - 2 add, 3 sub, 4 and, 5 or, 6 xor, 7 slt, 8 sll, 9 srl: ALU ops, sequence below.
  - 11..15 illegal: T1 Done, no register, A, G or Z write.
- ALU sequence:
  - T1: bus=Rx, A<=bus.
  - T2: bus=Ry, G<=A op bus, Z<=(result==0).
  - T3: bus=G, Rx<=G, Done.
- After the Done cycle, the next state is T0.
- Arithmetic:
  - add/sub modulo 2^WIDTH.
  - slt is signed compare, result 1 or 0.
  - sll/srl shift amount = bus[clog2(WIDTH)-1:0], logical shift, zero fill.
- Bus priority: exactly one source is driven per cycle; when no source is driven the bus is 0.
- Done is combinational from step and op; no glitch beyond the step decode.
- Reset values: all Rx, A, G and IR = 0; Z = 1; step = T0; Done = 0; BusWires = 0.
- Reset mid-instruction: immediately returns to T0; the in-flight write is abandoned.
- Run is ignored outside T0. DIN is ignored outside T0, except in T1 of mvi.
- Rx==Ry is legal for all ops; e.g. add R1,R1 doubles R1.

Optional Feature:
- Macro PROC_FLAGS_EN.
- Defined:
  - Adds an output port Flags[3:0] = {N,Z,C,V}, updated in T2 of ALU ops only.
  - C = carry out of add, or borrow (inverted carry) of sub; cleared by other ops.
  - V = signed overflow for add/sub; cleared by other ops.
  - N = result MSB.
  - Adds opcode 11 mvc: T1 conditional move when C=1, same timing as mvnz.
  - Reset value of Flags: 4'b0100.
- Undefined: no Flags port; opcode 11 is illegal; Z is still kept internally for mvnz.

Decomposition:
- Package proc_pkg:
  - opcode localparams or enum (OP_MV..OP_MVNZ, OP_MVC);
  - step enum T0..T3;
  - ALU operation select type;
  - clog2 helper function.
- Sub-module proc_alu: purely combinational, parametrised by WIDTH.
  - Inputs: a, b, op.
  - Outputs: result, zero; plus carry and overflow under PROC_FLAGS_EN.
- Register file, step counter and bus multiplexer live inside proc_param.

Test Plan (all at WIDTH=16, NREGS=8):
- Immediate load: mvi R0 with DIN=0x1234 in T1 -> Done in T1; R0 = 0x1234; BusWires = 0x1234 in that cycle.
- Add and conditional move:
  - add R1,R0 with R1=0x0001, R0=0xFFFF -> R1 = 0x0000 at T3 with Done; Z=1.
  - A following mvnz R2,R0 leaves R2 unchanged.
- Signed compare and shift:
  - slt R3,R4 with R3=0x8000, R4=0x0001 -> R3 = 0x0001.
  - sll R5,R6 with R5=0x0003, R6=0x0014 -> R5 = 0x0030 (shift amount 4).
- Idle and illegal opcode:
  - Run=0 for 5 cycles -> no Done, registers stable.
  - op=13 -> Done in T1, all registers and Z unchanged.
- Reset mid-instruction: assert Resetn=0 during T2 of sub -> step returns to T0, all registers = 0, Done = 0, with no clock edge required.
- PROC_FLAGS_EN: add 0x7FFF + 0x0001 -> Flags = {N=1, Z=0, C=0, V=1}; sub 0x0000 - 0x0001 -> C=1, N=1.
